jesd204b_rx_lane_ctrl: RTL and testbench

Per-lane JESD204B receive link controller that sequences the lane through Code Group Synchronisation (CGS), Initial Lane Alignment Sequence (ILAS) and user-data phases. It consumes 8b/10b-decoded octets plus K-flags and drives the SYNC~ request. It also gates the descrambler by driving its reset and enable, and forwards data only once the link is up. It sits between the 8b/10b decoder and jesd204b_descrambler in the receiver.

---
 rtl/jesd204b_rx_lane_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_jesd204b_rx_lane_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jesd204b_rx_lane_ctrl
// Description : Per-lane JESD204B receive link controller. Walks the lane
//               through code group sync, initial lane alignment and user
//               data, drives SYNC~, gates the descrambler and forwards data
//               once the link is up.
// Revision    : 1.0 - initial release
// ============================================================================
module jesd204b_rx_lane_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MF_CYCLES  = 8,
    parameter int CGS_COUNT  = 4,
    parameter int ILAS_MF    = 4,
    parameter int ERR_THRESH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_charisk,
    input  logic                    in_valid,
    input  logic                    scr_en,
    output logic                    sync_n,
    output logic                    descr_rst,
    output logic                    descr_en,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic                    link_up,
    output logic [1:0]              state,
    output logic                    ilas_err
);

    localparam int c_NO    = DATA_WIDTH / 8;
    localparam int c_CGS_W = $clog2(CGS_COUNT) + 1;
    localparam int c_MF_W  = $clog2(MF_CYCLES) + 1;
    localparam int c_IDX_W = $clog2(ILAS_MF) + 1;
    localparam int c_ERR_W = $clog2(ERR_THRESH) + 1;

    localparam logic [c_CGS_W-1:0] c_CGS_LAST = c_CGS_W'(CGS_COUNT - 1);
    localparam logic [c_MF_W-1:0]  c_MF_LAST  = c_MF_W'(MF_CYCLES - 1);
    localparam logic [c_MF_W-1:0]  c_MF_ONE   = c_MF_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(ILAS_MF - 1);
    localparam logic [c_ERR_W-1:0] c_ERR_LAST = c_ERR_W'(ERR_THRESH - 1);

    localparam logic [1:0] c_ST_CGS       = 2'd0;
    localparam logic [1:0] c_ST_ILAS_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ILAS      = 2'd2;
    localparam logic [1:0] c_ST_DATA      = 2'd3;

    logic [1:0]            r_state;
    logic [c_CGS_W-1:0]    r_cgs_cnt;
    logic [c_MF_W-1:0]     r_mf_cyc;
    logic [c_IDX_W-1:0]    r_mf_idx;
    logic [c_ERR_W-1:0]    r_err_cnt;
    logic                  r_sync_n;
    logic                  r_ilas_err;
    logic                  r_descr_en;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [1:0]            w_state_nxt;
    logic [c_CGS_W-1:0]    w_cgs_nxt;
    logic [c_MF_W-1:0]     w_mf_cyc_nxt;
    logic [c_IDX_W-1:0]    w_mf_idx_nxt;
    logic [c_ERR_W-1:0]    w_err_nxt;
    logic                  w_sync_nxt;
    logic                  w_ilas_err_nxt;
    logic                  w_descr_en_nxt;
    logic                  w_fail;

    logic [c_NO-1:0]       w_is_kbc;
    logic [c_NO-1:0]       w_bad_k;
    logic                  w_kcyc;
    logic                  w_rstart;
    logic                  w_aend;
    logic                  w_errcyc;
    logic                  w_fwd;

    // Per-octet classification; octet 0 sits in the MSBs and pairs with the
    // top K-flag bit.
    generate
        for (genvar gi = 0; gi < c_NO; gi++) begin : g_octet
            logic [7:0] w_oct;
            logic       w_k;
            assign w_oct        = in_data[DATA_WIDTH-1-8*gi -: 8];
            assign w_k          = in_charisk[c_NO-1-gi];
            assign w_is_kbc[gi] = w_k && (w_oct == 8'hBC);
            assign w_bad_k[gi]  = w_k && (w_oct != 8'h7C) && (w_oct != 8'hFC);
        end
    endgenerate

    assign w_kcyc   = &w_is_kbc;
    assign w_errcyc = |w_bad_k;
    assign w_rstart = (in_data[DATA_WIDTH-1 -: 8] == 8'h1C) && in_charisk[c_NO-1];
    assign w_aend   = (in_data[7:0] == 8'h7C) && in_charisk[0];

    // Next-state and counter logic; only qualified cycles move anything.
    always_comb begin
        w_state_nxt    = r_state;
        w_cgs_nxt      = r_cgs_cnt;
        w_mf_cyc_nxt   = r_mf_cyc;
        w_mf_idx_nxt   = r_mf_idx;
        w_err_nxt      = r_err_cnt;
        w_sync_nxt     = r_sync_n;
        w_ilas_err_nxt = 1'b0;
        w_descr_en_nxt = r_descr_en;
        w_fail         = 1'b0;
        if (in_valid) begin
            case (r_state)
                c_ST_CGS: begin
                    if (w_kcyc) begin
                        if (r_cgs_cnt == c_CGS_LAST) begin
                            w_state_nxt = c_ST_ILAS_WAIT;
                            w_sync_nxt  = 1'b1;
                            w_cgs_nxt   = '0;
                        end else begin
                            w_cgs_nxt = r_cgs_cnt + 1'b1;
                        end
                    end else begin
                        w_cgs_nxt = '0;
                    end
                end
                c_ST_ILAS_WAIT: begin
                    if (w_rstart) begin
                        // This cycle is already cycle 0 of multiframe 0.
                        w_state_nxt  = c_ST_ILAS;
                        w_mf_cyc_nxt = c_MF_ONE;
                        w_mf_idx_nxt = '0;
                    end else if (!w_kcyc) begin
                        w_fail         = 1'b1;
                        w_ilas_err_nxt = 1'b1;
                    end
                end
                c_ST_ILAS: begin
                    if (((r_mf_cyc == '0) && !w_rstart) ||
                        ((r_mf_cyc == c_MF_LAST) && !w_aend)) begin
                        w_fail         = 1'b1;
                        w_ilas_err_nxt = 1'b1;
                    end else if (r_mf_cyc == c_MF_LAST) begin
                        w_mf_cyc_nxt = '0;
                        if (r_mf_idx == c_IDX_LAST) begin
                            w_state_nxt    = c_ST_DATA;
                            w_mf_idx_nxt   = '0;
                            w_err_nxt      = '0;
                            w_descr_en_nxt = scr_en;
                        end else begin
                            w_mf_idx_nxt = r_mf_idx + 1'b1;
                        end
                    end else begin
                        w_mf_cyc_nxt = r_mf_cyc + 1'b1;
                    end
                end
                default: begin
                    if (w_errcyc) begin
                        if (r_err_cnt == c_ERR_LAST) begin
                            w_fail = 1'b1;
                        end else begin
                            w_err_nxt = r_err_cnt + 1'b1;
                        end
                    end else begin
                        w_err_nxt = '0;
                    end
                end
            endcase
            if (w_fail) begin
                w_state_nxt    = c_ST_CGS;
                w_sync_nxt     = 1'b0;
                w_cgs_nxt      = '0;
                w_mf_cyc_nxt   = '0;
                w_mf_idx_nxt   = '0;
                w_err_nxt      = '0;
                w_descr_en_nxt = 1'b0;
            end
        end
    end

    // State, counter and control-output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_CGS;
            r_cgs_cnt  <= '0;
            r_mf_cyc   <= '0;
            r_mf_idx   <= '0;
            r_err_cnt  <= '0;
            r_sync_n   <= 1'b0;
            r_ilas_err <= 1'b0;
            r_descr_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cgs_cnt  <= w_cgs_nxt;
            r_mf_cyc   <= w_mf_cyc_nxt;
            r_mf_idx   <= w_mf_idx_nxt;
            r_err_cnt  <= w_err_nxt;
            r_sync_n   <= w_sync_nxt;
            r_ilas_err <= w_ilas_err_nxt;
            r_descr_en <= w_descr_en_nxt;
        end
    end

    // Forward only while DATA is both current and next, so the word that
    // trips resync is dropped and the entry edge forwards nothing.
    assign w_fwd = (r_state == c_ST_DATA) && (w_state_nxt == c_ST_DATA);

    // One-cycle data pipeline to the descrambler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_fwd && in_valid;
            if (w_fwd && in_valid) begin
                r_out_data <= in_data;
            end
        end
    end

    assign state     = r_state;
    assign sync_n    = r_sync_n;
    assign ilas_err  = r_ilas_err;
    assign link_up   = (r_state == c_ST_DATA);
    assign descr_rst = (r_state != c_ST_DATA);
    assign descr_en  = r_descr_en;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_rx_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jesd204b_rx_lane_ctrl
// Description : Directed, table-driven bench for jesd204b_rx_lane_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd204b_rx_lane_ctrl;

    localparam int c_MF = 8;
    localparam int c_NMF = 4;
    localparam logic [31:0] c_KW = 32'hBCBC_BCBC;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic        scr;
        logic [1:0]  st;
        logic        sync;
        logic        den;
        logic        ov;
        logic [31:0] od;
        logic        chk_od;
        logic        ierr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_charisk;
    logic        in_valid;
    logic        scr_en;
    logic        sync_n;
    logic        descr_rst;
    logic        descr_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        link_up;
    logic [1:0]  state;
    logic        ilas_err;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    jesd204b_rx_lane_ctrl #(
        .DATA_WIDTH (32),
        .MF_CYCLES  (c_MF),
        .CGS_COUNT  (4),
        .ILAS_MF    (c_NMF),
        .ERR_THRESH (3)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_charisk (in_charisk),
        .in_valid   (in_valid),
        .scr_en     (scr_en),
        .sync_n     (sync_n),
        .descr_rst  (descr_rst),
        .descr_en   (descr_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .link_up    (link_up),
        .state      (state),
        .ilas_err   (ilas_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [31:0] d, logic [3:0] k, logic scr,
                                logic [1:0] st, logic sync, logic den, logic ov,
                                logic [31:0] od, logic chk_od, logic ierr);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.scr = scr; r.st = st; r.sync = sync;
        r.den = den; r.ov = ov; r.od = od; r.chk_od = chk_od; r.ierr = ierr;
        return r;
    endfunction

    // Valid all-/K/ cycle with the expected state/sync after the edge.
    function automatic vec_t kv(logic [1:0] st, logic sync);
        return mk(1'b1, c_KW, 4'hF, 1'b0, st, sync, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    // ILAS word i (multiframe i/8, cycle i%8); good=0 breaks the /A/ at MF end.
    function automatic void ilas_word(int i, logic good, output logic [31:0] d, output logic [3:0] k);
        logic [7:0] m;
        logic [7:0] c;
        m = 8'(i / c_MF);
        c = 8'(i % c_MF);
        if (c == 8'd0) begin
            d = {8'h1C, m, c, 8'h00}; k = 4'b1000;
        end else if (c == 8'(c_MF - 1)) begin
            d = {8'h00, m, c, good ? 8'h7C : 8'h00}; k = good ? 4'b0001 : 4'b0000;
        end else begin
            d = {8'h00, m, c, 8'h55}; k = 4'b0000;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input vec_t v);
        chk("state", 32'(state), 32'(v.st));
        chk("sync_n", 32'(sync_n), 32'(v.sync));
        chk("link_up", 32'(link_up), 32'(v.st == 2'd3));
        chk("descr_rst", 32'(descr_rst), 32'(v.st != 2'd3));
        chk("descr_en", 32'(descr_en), 32'(v.den));
        chk("out_valid", 32'(out_valid), 32'(v.ov));
        chk("ilas_err", 32'(ilas_err), 32'(v.ierr));
        if (v.chk_od) chk("out_data", out_data, v.od);
    endtask

    task automatic apply(input vec_t v);
        in_valid   = v.v;
        in_data    = v.d;
        in_charisk = v.k;
        scr_en     = v.scr;
        @(posedge clk);
        #1;
        check_outputs(v);
    endtask

    // Run ncyc ILAS cycles; cycle bad_at (if >= 0) carries a broken /A/.
    task automatic run_ilas(input int ncyc, input logic scr, input int bad_at);
        logic [31:0] d;
        logic [3:0]  k;
        for (int i = 0; i < ncyc; i++) begin
            ilas_word(i, i != bad_at, d, k);
            if (i == bad_at) begin
                apply(mk(1'b1, d, k, scr, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
                break;
            end else if (i == c_MF * c_NMF - 1) begin
                apply(mk(1'b1, d, k, scr, 2'd3, 1'b1, scr, 1'b0, 32'h0, 1'b0, 1'b0));
            end else begin
                apply(mk(1'b1, d, k, scr, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        vec_t idle;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_charisk = '0; scr_en = 1'b0;
        idle = mk(1'b0, c_KW, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset values.
        #1;
        check_outputs(mk(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        #1 reset = 1'b1;

        // CGS with in_valid toggling: only valid K cycles count.
        tbl.push_back(kv(2'd0, 1'b0)); tbl.push_back(idle);
        tbl.push_back(kv(2'd0, 1'b0)); tbl.push_back(idle);
        tbl.push_back(kv(2'd0, 1'b0)); tbl.push_back(idle);
        tbl.push_back(kv(2'd1, 1'b1));
        tbl.push_back(kv(2'd1, 1'b1));
        // Garbage in ILAS_WAIT -> error pulse, back to CGS.
        tbl.push_back(mk(1'b1, 32'h11223344, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
        // Interrupted CGS run restarts the count.
        for (int i = 0; i < 3; i++) tbl.push_back(kv(2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h11223344, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(kv(2'd0, 1'b0));
        tbl.push_back(kv(2'd1, 1'b1));
        // Clean ILAS with scrambling requested.
        for (int i = 0; i < c_MF * c_NMF; i++) begin
            ilas_word(i, 1'b1, d, k);
            if (i == c_MF * c_NMF - 1)
                tbl.push_back(mk(1'b1, d, k, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
            else
                tbl.push_back(mk(1'b1, d, k, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        end
        // DATA: forwarding with 1-cycle latency; scr_en change ignored.
        tbl.push_back(mk(1'b1, 32'hDEADBEEF, 4'h0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 32'h01020304, 4'h0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 32'h01020304, 1'b1, 1'b0));
        // Error counting: two errored, clean (/A/ /F/ allowed), then 3 errored with an idle between.
        tbl.push_back(mk(1'b1, 32'hBC000000, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 32'hBC000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, c_KW, 4'hF, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, c_KW, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 32'h7CFC0000, 4'b1100, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 32'h7CFC0000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 32'h00000011, 4'b0001, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 32'h00000011, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 32'h55555555, 4'h0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h00110000, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 32'h00110000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 32'h000000BC, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));

        foreach (tbl[i]) apply(tbl[i]);

        // ILAS framing error at the end of multiframe 2.
        for (int i = 0; i < 3; i++) apply(kv(2'd0, 1'b0));
        apply(kv(2'd1, 1'b1));
        run_ilas(c_MF * c_NMF, 1'b0, 2 * c_MF + c_MF - 1);
        apply(kv(2'd0, 1'b0));
        for (int i = 0; i < 2; i++) apply(kv(2'd0, 1'b0));
        apply(kv(2'd1, 1'b1));
        // Clean ILAS with scrambling off: descrambler stays disabled.
        run_ilas(c_MF * c_NMF, 1'b0, -1);
        apply(mk(1'b1, 32'hCAFEF00D, 4'h0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0));
        apply(mk(1'b1, 32'hFC00BC00, 4'b0010, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hFC00BC00, 1'b1, 1'b0));
        apply(mk(1'b1, 32'hBC000000, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hBC000000, 1'b1, 1'b0));
        apply(mk(1'b1, c_KW, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));

        // Asynchronous reset mid-ILAS, between clock edges.
        for (int i = 0; i < 3; i++) apply(kv(2'd0, 1'b0));
        apply(kv(2'd1, 1'b1));
        run_ilas(10, 1'b1, -1);
        #2 reset = 1'b0;
        #1;
        check_outputs(mk(1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) apply(kv(2'd0, 1'b0));
        apply(kv(2'd1, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
